// File: rtl/address_offset_writer.sv
// Write-side producer for the PO/DO offset memories: decodes datapath result writes and
// slots host-loaded entries into the owning thread's cycle. Optional macro: OFFSET_WRITER_COLLISION_COUNT_EN.
`timescale 1ns/1ps
module address_offset_writer #(
    parameter int WORD_WIDTH         = 36,
    parameter int WRITE_ADDR_WIDTH   = 10,
    parameter int ADDR_WIDTH         = 10,
    parameter int PO_INCR_WIDTH      = 4,
    parameter int PO_ENTRY_WIDTH     = PO_INCR_WIDTH + ADDR_WIDTH,
    parameter int PO_ENTRY_COUNT     = 4,
    parameter int PO_ADDR_WIDTH      = 2,
    parameter logic [WRITE_ADDR_WIDTH-1:0] PO_BASE = 10'h3F0,
    parameter logic [WRITE_ADDR_WIDTH-1:0] DO_ADDR = 10'h3F8,
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3,
    parameter int INITIAL_THREAD     = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          write_en,
    input  logic [WRITE_ADDR_WIDTH-1:0]   write_addr,
    input  logic [WORD_WIDTH-1:0]         write_data,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic                          load_is_do,
    input  logic [THREAD_COUNT_WIDTH-1:0] load_thread,
    input  logic [PO_ADDR_WIDTH-1:0]      load_entry,
    input  logic [PO_ENTRY_WIDTH-1:0]     load_data,
    output logic                          load_done,
    output logic                          po_wren,
    output logic [PO_ADDR_WIDTH-1:0]      po_write_addr,
    output logic [PO_ENTRY_WIDTH-1:0]     po_write_data,
    output logic                          do_wren,
    output logic [ADDR_WIDTH-1:0]         do_write_data
`ifdef OFFSET_WRITER_COLLISION_COUNT_EN
    ,
    output logic [15:0]                   collision_count
`endif
);

    localparam logic [WRITE_ADDR_WIDTH:0] PO_END =
        {1'b0, PO_BASE} + (WRITE_ADDR_WIDTH+1)'(PO_ENTRY_COUNT);
    localparam logic [THREAD_COUNT_WIDTH-1:0] LAST_THREAD  = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
    localparam logic [THREAD_COUNT_WIDTH-1:0] FIRST_THREAD = THREAD_COUNT_WIDTH'(INITIAL_THREAD);

    typedef enum logic {
        IDLE,
        WAIT_SLOT
    } state_t;

    state_t                          state;
    logic [THREAD_COUNT_WIDTH-1:0]   slot_thread;
    logic [THREAD_COUNT_WIDTH-1:0]   req_thread;
    logic                            req_is_do;
    logic [PO_ADDR_WIDTH-1:0]        req_entry;
    logic [PO_ENTRY_WIDTH-1:0]       req_data;

    logic [WRITE_ADDR_WIDTH-1:0]     po_offset;
    logic                            po_hit;
    logic                            do_hit;
    logic                            slot_match;
    logic                            host_blocked;
    logic                            issue;
    logic                            collide;
    logic                            host_po;
    logic                            host_do;
    logic                            unused_bits;

    assign po_offset    = write_addr - PO_BASE;
    assign po_hit       = write_en && (write_addr >= PO_BASE) && ({1'b0, write_addr} < PO_END);
    assign do_hit       = write_en && (write_addr == DO_ADDR);
    assign slot_match   = (state == WAIT_SLOT) && (slot_thread == req_thread);
    // The datapath owns the slot; the host only loses when both target the same memory.
    assign host_blocked = req_is_do ? do_hit : po_hit;
    assign issue        = slot_match && !host_blocked;
    assign collide      = slot_match && host_blocked;
    assign host_po      = issue && !req_is_do;
    assign host_do      = issue && req_is_do;
    assign load_ready   = (state == IDLE);
    assign unused_bits  = ^{write_data[WORD_WIDTH-1:PO_ENTRY_WIDTH],
                            po_offset[WRITE_ADDR_WIDTH-1:PO_ADDR_WIDTH]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_thread <= FIRST_THREAD;
        end else if (slot_thread == LAST_THREAD) begin
            slot_thread <= '0;
        end else begin
            slot_thread <= slot_thread + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_thread <= '0;
            req_is_do  <= 1'b0;
            req_entry  <= '0;
            req_data   <= '0;
            load_done  <= 1'b0;
        end else begin
            load_done <= issue;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        req_thread <= load_thread;
                        req_is_do  <= load_is_do;
                        req_entry  <= load_entry;
                        req_data   <= load_data;
                        state      <= WAIT_SLOT;
                    end
                end
                WAIT_SLOT: begin
                    if (issue) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            po_wren       <= 1'b0;
            po_write_addr <= '0;
            po_write_data <= '0;
            do_wren       <= 1'b0;
            do_write_data <= '0;
        end else begin
            po_wren <= po_hit || host_po;
            do_wren <= do_hit || host_do;
            if (po_hit) begin
                po_write_addr <= po_offset[PO_ADDR_WIDTH-1:0];
                po_write_data <= write_data[PO_ENTRY_WIDTH-1:0];
            end else if (host_po) begin
                po_write_addr <= req_entry;
                po_write_data <= req_data;
            end
            if (do_hit) begin
                do_write_data <= write_data[ADDR_WIDTH-1:0];
            end else if (host_do) begin
                do_write_data <= req_data[ADDR_WIDTH-1:0];
            end
        end
    end

`ifdef OFFSET_WRITER_COLLISION_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            collision_count <= '0;
        end else if (collide && (collision_count != 16'hFFFF)) begin
            collision_count <= collision_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_address_offset_writer.sv
// Directed bench for address_offset_writer; slot position is tracked by a local thread counter.
`timescale 1ns/1ps
module tb_address_offset_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        write_en;
    logic [9:0]  write_addr;
    logic [35:0] write_data;
    logic        load_valid;
    logic        load_ready;
    logic        load_is_do;
    logic [2:0]  load_thread;
    logic [1:0]  load_entry;
    logic [13:0] load_data;
    logic        load_done;
    logic        po_wren;
    logic [1:0]  po_write_addr;
    logic [13:0] po_write_data;
    logic        do_wren;
    logic [9:0]  do_write_data;
`ifdef OFFSET_WRITER_COLLISION_COUNT_EN
    logic [15:0] collision_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [2:0] slot;

    address_offset_writer dut (
        .clock(clock), .reset(reset),
        .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
        .load_valid(load_valid), .load_ready(load_ready), .load_is_do(load_is_do),
        .load_thread(load_thread), .load_entry(load_entry), .load_data(load_data),
        .load_done(load_done),
        .po_wren(po_wren), .po_write_addr(po_write_addr), .po_write_data(po_write_data),
        .do_wren(do_wren), .do_write_data(do_write_data)
`ifdef OFFSET_WRITER_COLLISION_COUNT_EN
        , .collision_count(collision_count)
`endif
    );

    always #5 clock = ~clock;

    // Thread owning the upcoming posedge, as seen from the preceding negedge.
    always @(posedge clock or posedge reset) begin
        if (reset) slot <= 3'd0;
        else       slot <= slot + 3'd1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_slot(input logic [2:0] s);
        for (int i = 0; i < 8 && slot != s; i++) tick();
    endtask

    task automatic dp_write(input logic [9:0] a, input logic [35:0] d);
        write_en = 1'b1; write_addr = a; write_data = d;
    endtask

    task automatic host_req(input logic is_do, input logic [2:0] th,
                            input logic [1:0] en, input logic [13:0] d);
        load_valid = 1'b1; load_is_do = is_do; load_thread = th; load_entry = en; load_data = d;
    endtask

    initial begin
        reset = 1'b1; write_en = 1'b0; write_addr = '0; write_data = '0;
        load_valid = 1'b0; load_is_do = 1'b0; load_thread = '0; load_entry = '0; load_data = '0;
        tick(); tick();
        check("rst_po_wren", po_wren, 0);
        check("rst_do_wren", do_wren, 0);
        check("rst_load_done", load_done, 0);
        reset = 1'b0;
        tick();
        check("rst_load_ready", load_ready, 1);
        check("rst_po_data", po_write_data, 0);

        // Datapath PO write, then hold when enable drops
        dp_write(10'h3F2, 36'h0000_0A123);
        tick();
        check("dp_po_wren", po_wren, 1);
        check("dp_po_addr", po_write_addr, 2);
        check("dp_po_data", po_write_data, 14'h2123);
        check("dp_po_no_do", do_wren, 0);
        write_en = 1'b0;
        tick();
        check("dp_po_pulse", po_wren, 0);
        check("dp_po_hold", po_write_data, 14'h2123);

        // Datapath DO write and misses around the mapped window
        dp_write(10'h3F8, 36'h155);
        tick();
        check("dp_do_wren", do_wren, 1);
        check("dp_do_data", do_write_data, 10'h155);
        check("dp_do_no_po", po_wren, 0);
        dp_write(10'h3F9, 36'h2AA);
        tick();
        check("miss_3f9_do", do_wren, 0);
        check("miss_3f9_po", po_wren, 0);
        check("miss_do_hold", do_write_data, 10'h155);
        dp_write(10'h3F4, 36'h1);
        tick();
        check("miss_3f4_po", po_wren, 0);
        dp_write(10'h3EF, 36'h1);
        tick();
        check("miss_3ef_po", po_wren, 0);
        dp_write(10'h3F3, 36'hF_FFFF_3FFF);
        tick();
        check("edge_3f3_wren", po_wren, 1);
        check("edge_3f3_addr", po_write_addr, 3);
        check("edge_3f3_data", po_write_data, 14'h3FFF);
        write_en = 1'b0;

        // Host PO load for thread 5 captured at slot 2
        wait_slot(3'd2);
        host_req(1'b0, 3'd5, 2'd1, 14'h1ABC);
        tick();
        load_valid = 1'b0;
        check("host_busy", load_ready, 0);
        tick();
        check("host_wait_done", load_done, 0);
        tick();
        check("host_wait_wren", po_wren, 0);
        tick();
        check("host_po_wren", po_wren, 1);
        check("host_po_addr", po_write_addr, 1);
        check("host_po_data", po_write_data, 14'h1ABC);
        check("host_done", load_done, 1);
        check("host_ready", load_ready, 1);
        tick();
        check("host_done_pulse", load_done, 0);

        // Collision: datapath PO wins at slot 3; host retries one rotation later
        wait_slot(3'd0);
        host_req(1'b0, 3'd3, 2'd2, 14'h0777);
        tick();
        load_valid = 1'b0;
        tick(); tick();
        dp_write(10'h3F1, 36'h0000_05555);
        tick();
        write_en = 1'b0;
        check("col_dp_wren", po_wren, 1);
        check("col_dp_addr", po_write_addr, 1);
        check("col_dp_data", po_write_data, 14'h1555);
        check("col_no_done", load_done, 0);
`ifdef OFFSET_WRITER_COLLISION_COUNT_EN
        check("col_count", collision_count, 1);
`endif
        for (int i = 0; i < 7; i++) begin
            tick();
            check("col_retry_wait", {po_wren, load_done}, 2'b00);
        end
        tick();
        check("col_host_wren", po_wren, 1);
        check("col_host_addr", po_write_addr, 2);
        check("col_host_data", po_write_data, 14'h0777);
        check("col_host_done", load_done, 1);

        // Cross-target: host DO and datapath PO in the same slot both land
        wait_slot(3'd1);
        host_req(1'b1, 3'd4, 2'd3, 14'h3233);
        tick();
        load_valid = 1'b0;
        tick(); tick();
        dp_write(10'h3F0, 36'h3);
        tick();
        write_en = 1'b0;
        check("x_po_wren", po_wren, 1);
        check("x_do_wren", do_wren, 1);
        check("x_po_addr", po_write_addr, 0);
        check("x_po_data", po_write_data, 14'h0003);
        check("x_do_data", do_write_data, 10'h233);
        check("x_done", load_done, 1);
`ifdef OFFSET_WRITER_COLLISION_COUNT_EN
        check("x_count", collision_count, 1);
`endif

        // Request captured in its own slot waits a full rotation
        wait_slot(3'd6);
        host_req(1'b1, 3'd6, 2'd0, 14'h00AA);
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("own_slot_wait", {do_wren, load_done}, 2'b00);
        end
        tick();
        check("own_slot_wren", do_wren, 1);
        check("own_slot_data", do_write_data, 10'h0AA);
        check("own_slot_done", load_done, 1);

        // Reset mid-request drops the pending entry
        host_req(1'b0, 3'd2, 2'd3, 14'h1111);
        tick();
        load_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_po_data", po_write_data, 0);
        check("mid_rst_do_data", do_write_data, 0);
        check("mid_rst_done", load_done, 0);
`ifdef OFFSET_WRITER_COLLISION_COUNT_EN
        check("mid_rst_count", collision_count, 0);
`endif
        tick();
        reset = 1'b0;
        check("mid_rst_ready", load_ready, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mid_rst_dropped", {po_wren, load_done}, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
